// File: rtl/mwram_if.sv
// mwram_if: bundles the write ports, the read port and the conflict flag of
// the multi-write RAM. The master drives writes and the read address; the
// slave (the RAM) returns registered read data and the conflict pulse.
interface mwram_if #(
    parameter int ADDRW   = 4,
    parameter int DATAW   = 32,
    parameter int nWPORTS = 2
);
    logic [nWPORTS-1:0]       WEnb;
    logic [ADDRW*nWPORTS-1:0] WAddr;
    logic [DATAW*nWPORTS-1:0] WData;
    logic [ADDRW-1:0]         RAddr;
    logic [DATAW-1:0]         RData;
    logic                     WConf;

    modport master (
        output WEnb, WAddr, WData, RAddr,
        input  RData, WConf
    );

    modport slave (
        input  WEnb, WAddr, WData, RAddr,
        output RData, WConf
    );
endinterface

// File: rtl/mwram.sv
// mwram: multi-write-port, single-read-port RAM built from one private bank
// per write port plus a live value table (LVT) that remembers, per address,
// which bank holds the newest value. The read port selects through the LVT.
//
// Optional feature: define MWRAM_BYPASS_EN to forward same-edge write data
// to the read port (read-during-write returns new data). Without it the read
// returns the value stored before the edge.
module mwram #(
    parameter int MEMD    = 16,
    parameter int DATAW   = 32,
    parameter int nWPORTS = 2,
    parameter int IZERO   = 0
) (
    input  logic   clk,
    input  logic   rstn,
    mwram_if.slave bus
);
    localparam int ADDRW = $clog2(MEMD);
    localparam int LVTW  = $clog2(nWPORTS);

    // Per-bank asynchronous read of the current read address.
    logic [nWPORTS-1:0][DATAW-1:0] bank_rd;

    // LVT: newest-writer index per address; cleared to bank 0 by reset.
    logic [LVTW-1:0]  lvt_reg [MEMD];
    logic [LVTW-1:0]  rd_sel;
    logic [DATAW-1:0] rdata_reg;
    logic [DATAW-1:0] rdata_next;
    logic             wconf_reg;
    logic             wconf_next;

    // One bank per write port; only port gi ever writes bank gi.
    for (genvar gi = 0; gi < nWPORTS; gi++) begin : g_bank
        if (IZERO != 0) begin : g_zero
            logic [DATAW-1:0] mem [MEMD] = '{default: '0};

            // Bank write; writes are dropped while reset is held.
            always_ff @(posedge clk) begin
                if (rstn && bus.WEnb[gi]) begin
                    mem[bus.WAddr[gi*ADDRW +: ADDRW]] <= bus.WData[gi*DATAW +: DATAW];
                end
            end

            assign bank_rd[gi] = mem[bus.RAddr];
        end else begin : g_undef
            logic [DATAW-1:0] mem [MEMD];

            // Bank write; writes are dropped while reset is held.
            always_ff @(posedge clk) begin
                if (rstn && bus.WEnb[gi]) begin
                    mem[bus.WAddr[gi*ADDRW +: ADDRW]] <= bus.WData[gi*DATAW +: DATAW];
                end
            end

            assign bank_rd[gi] = mem[bus.RAddr];
        end
    end

    // LVT update: ascending port order makes the highest-index port win on
    // a same-address conflict (last non-blocking assignment takes effect).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int a = 0; a < MEMD; a++) begin
                lvt_reg[a] <= '0;
            end
        end else begin
            for (int i = 0; i < nWPORTS; i++) begin
                if (bus.WEnb[i]) begin
                    lvt_reg[bus.WAddr[i*ADDRW +: ADDRW]] <= LVTW'(i);
                end
            end
        end
    end

    // Conflict detect: any pair of enabled ports aiming at the same address.
    always_comb begin
        wconf_next = 1'b0;
        for (int i = 0; i < nWPORTS; i++) begin
            for (int j = i + 1; j < nWPORTS; j++) begin
                if (bus.WEnb[i] && bus.WEnb[j] &&
                    (bus.WAddr[i*ADDRW +: ADDRW] == bus.WAddr[j*ADDRW +: ADDRW])) begin
                    wconf_next = 1'b1;
                end
            end
        end
    end

    assign rd_sel = lvt_reg[bus.RAddr];

`ifdef MWRAM_BYPASS_EN
    // Read select with forwarding: a same-edge write to RAddr overrides the
    // stored value; scanning upward lets the highest matching port win.
    always_comb begin
        rdata_next = bank_rd[rd_sel];
        for (int i = 0; i < nWPORTS; i++) begin
            if (bus.WEnb[i] && (bus.WAddr[i*ADDRW +: ADDRW] == bus.RAddr)) begin
                rdata_next = bus.WData[i*DATAW +: DATAW];
            end
        end
    end
`else
    // Read select: LVT lookup steers the bank mux; pre-edge contents only.
    always_comb begin
        rdata_next = bank_rd[rd_sel];
    end
`endif

    // Output registers: read data every cycle, conflict flag as a pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_reg <= '0;
            wconf_reg <= 1'b0;
        end else begin
            rdata_reg <= rdata_next;
            wconf_reg <= wconf_next;
        end
    end

    assign bus.RData = rdata_reg;
    assign bus.WConf = wconf_reg;
endmodule
